// File: rtl/xpb_table_gen.sv
// Writer for the digit-indexed xpb lookup table: entry k = (k*C) mod N, one entry per cycle.
// Optional base-range checking is compiled in with `define XPB_GEN_RANGE_CHECK_EN.
module xpb_table_gen #(
  parameter int WORD_W  = 1024,
  parameter int DIGIT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WORD_W-1:0]  modulus,
  input  logic [WORD_W-1:0]  base,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               wr_en,
  output logic [DIGIT_W-1:0] wr_addr,
  output logic [WORD_W-1:0]  wr_data
);

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    FIN
  } state_t;

  localparam logic [DIGIT_W-1:0] LAST_ADDR = {DIGIT_W{1'b1}};

  state_t            state;
  state_t            next_state;
  logic [WORD_W-1:0] mod_q;
  logic [WORD_W-1:0] base_q;
  logic [WORD_W:0]   sum;
  logic [WORD_W-1:0] next_entry;
  logic              range_bad;
  logic              start_ok;

`ifdef XPB_GEN_RANGE_CHECK_EN
  assign range_bad = (base >= modulus);
`else
  assign range_bad = 1'b0;
`endif

  assign start_ok = start && (state == IDLE) && !range_bad;

  // wr_data doubles as the running accumulator; the extra sum bit keeps the
  // compare exact, and the reduced result always fits back into WORD_W bits.
  assign sum        = {1'b0, wr_data} + {1'b0, base_q};
  assign next_entry = (sum >= {1'b0, mod_q}) ? (wr_data + base_q - mod_q)
                                             : (wr_data + base_q);

  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // active-low reset so every register clears the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    wr_en      = 1'b0;
    unique case (state)
      IDLE: if (start_ok) next_state = GEN;
      GEN: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        if (wr_addr == LAST_ADDR) next_state = FIN;
      end
      FIN: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_q   <= '0;
      base_q  <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (start_ok) begin
      mod_q   <= modulus;
      base_q  <= base;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (state == GEN && wr_addr != LAST_ADDR) begin
      wr_addr <= wr_addr + 1'b1;
      wr_data <= next_entry;
    end
  end

`ifdef XPB_GEN_RANGE_CHECK_EN
  // A rejected start leaves the FSM in IDLE; only a valid start clears the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (start && state == IDLE) begin
      err <= range_bad;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_xpb_table_gen.sv
// Self-checking bench for xpb_table_gen (WORD_W=16, DIGIT_W=5): expected entries are
// queued from a k*C mod N model at start and popped by a write monitor.
module tb_xpb_table_gen;

  localparam int WW      = 16;
  localparam int DW      = 5;
  localparam int ENTRIES = 1 << DW;

  typedef struct packed {
    logic [DW-1:0] addr;
    logic [WW-1:0] data;
  } wr_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [WW-1:0] modulus;
  logic [WW-1:0] base;
  logic          busy;
  logic          done;
  logic          err;
  logic          wr_en;
  logic [DW-1:0] wr_addr;
  logic [WW-1:0] wr_data;

  wr_t exp_q[$];
  wr_t mon_e;
  int  tests_run    = 0;
  int  tests_failed = 0;
  int  wr_cnt       = 0;
  int  done_cnt     = 0;

  xpb_table_gen #(
    .WORD_W (WW),
    .DIGIT_W(DW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .modulus(modulus),
    .base   (base),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        check("wr_data", 32'(wr_data), 32'(mon_e.data));
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic push_table(input int n, input int c);
    wr_t e;
    for (int k = 0; k < ENTRIES; k++) begin
      e.addr = DW'(k);
      e.data = WW'((k * c) % n);
      exp_q.push_back(e);
    end
  endtask

  // Called just after a falling edge; drives one run and checks its timing.
  task automatic run(input int n, input int c, input string tag);
    int lat;
    bit seen;
    seen = 1'b0;
    push_table(n, c);
    modulus = WW'(n);
    base    = WW'(c);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    modulus = 16'hffff;
    base    = 16'h1234;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    for (lat = 1; lat <= 100; lat++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (lat == 17) start = 1'b1;
      if (lat == 18) start = 1'b0;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd33);
    check({tag, "_wr_en_at_done"}, 32'(wr_en), 32'd0);
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    exp_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_fin_start_ignored"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_idle_after"}, 32'(busy | wr_en), 32'd0);
  endtask

  initial begin
    int saved_wr;
    int saved_done;
    bit hit;
    rst_n   = 1'b0;
    start   = 1'b0;
    modulus = '0;
    base    = '0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(97, 50, "m97_b50");
    run(2, 1, "m2_b1");
    run(97, 96, "m97_b96");
    run(97, 0, "m97_b0");

    // Asynchronous reset in the middle of a run.
    push_table(97, 50);
    modulus = 16'd97;
    base    = 16'd50;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit   = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (wr_en === 1'b1 && wr_addr == DW'(10)) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("mid_rst_reached_idx10", 32'(hit), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en_async", 32'(wr_en), 32'd0);
    check("mid_rst_busy_async", 32'(busy), 32'd0);
    check("mid_rst_wr_addr_async", 32'(wr_addr), 32'd0);
    exp_q.delete();
    saved_wr   = wr_cnt;
    saved_done = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("mid_rst_no_writes", 32'(wr_cnt), 32'(saved_wr));
    check("mid_rst_no_done", 32'(done_cnt), 32'(saved_done));
    run(97, 50, "after_rst");

`ifdef XPB_GEN_RANGE_CHECK_EN
    modulus = 16'd97;
    base    = 16'd97;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("range_err_set", 32'(err), 32'd1);
    check("range_busy", 32'(busy), 32'd0);
    saved_wr   = wr_cnt;
    saved_done = done_cnt;
    repeat (40) @(negedge clk);
    check("range_no_writes", 32'(wr_cnt), 32'(saved_wr));
    check("range_no_done", 32'(done_cnt), 32'(saved_done));
    check("range_err_held", 32'(err), 32'd1);
    run(97, 50, "after_err");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xpb_table_gen.md
XPB_TABLE_GEN -- requirements
Module: xpb_table_gen

Interface
REQ-001 SHALL expose parameters (one per line):
  WORD_W   1024  width of modulus, base and table entries
  DIGIT_W  5     table index width; the table holds 2^DIGIT_W entries
REQ-002 SHALL expose ports (one per line):
  clk      in   1          rising-edge clock; one clock domain only
  rst_n    in   1          asynchronous active-low reset
  start    in   1          generation request; sampled only in IDLE
  modulus  in   WORD_W     modulus N; sampled in the start cycle
  base     in   WORD_W     constant C (2^offset mod N); sampled in the start cycle; must be < N
  busy     out  1          high from the cycle after start until the done pulse, inclusive
  done     out  1          one-cycle completion pulse
  err      out  1          base-range error flag (see Configuration)
  wr_en    out  1          table write strobe
  wr_addr  out  DIGIT_W    table write index
  wr_data  out  WORD_W     table write value

Function
REQ-003 SHALL fill a table in which entry k equals (k*C) mod N, for k = 0 .. 2^DIGIT_W-1. This is the writer side of the digit-indexed xpb lookup table.
REQ-004 SHALL implement the FSM states IDLE, GEN and FIN.
- IDLE -> GEN on start=1.
- GEN -> FIN after the write of the last index.
- FIN -> IDLE unconditionally.
REQ-005 SHALL latch modulus and base into internal registers in the start cycle; input changes after that cycle SHALL NOT affect the run.
REQ-006 SHALL, in the first GEN cycle (the cycle after start), drive wr_en=1, wr_addr=0 and wr_data=0.
REQ-007 SHALL write exactly one entry per GEN cycle, with wr_addr incrementing by 1 each cycle and no gaps.
REQ-008 SHALL compute each next entry as follows: s = prev + C at WORD_W+1 bits; the entry is s-N if s >= N, otherwise s. Equality SHALL subtract.
REQ-009 SHALL perform the add, compare and subtract within a single cycle, with no multi-cycle paths.
REQ-010 SHALL, in the cycle after index 2^DIGIT_W-1 is written (FIN), drive done=1 and wr_en=0. Total latency from start to done is 2^DIGIT_W+1 cycles.
REQ-011 SHALL ignore start while busy=1. A start in the FIN cycle is also ignored; the next run needs a start in IDLE.
REQ-012 SHALL hold wr_en=0 whenever the state is not GEN. wr_addr and wr_data hold their last values outside GEN.
REQ-013 SHALL NOT wrap wr_addr past 2^DIGIT_W-1 within one run.

Reset
REQ-014 SHALL, on rst_n=0 and regardless of clk, force the following immediately:
- state=IDLE
- busy=0, done=0, err=0, wr_en=0
- wr_addr=0, wr_data=0
- internal modulus, base and accumulator registers to 0
REQ-015 SHALL, when reset is asserted mid-run, stop writing in the same instant (wr_en low asynchronously) and not resume after release. The table contents are then undefined until a new start.
REQ-016 SHALL accept start in the first clock edge after rst_n deasserts.

Configuration
REQ-017 SHALL compile range checking under the macro XPB_GEN_RANGE_CHECK_EN.
REQ-018 With XPB_GEN_RANGE_CHECK_EN defined, a start with base >= modulus SHALL:
- set err=1 in the next cycle
- perform no writes and assert no done
- return to IDLE
err SHALL stay set until the next accepted start with valid operands.
REQ-019 Without XPB_GEN_RANGE_CHECK_EN, err SHALL be tied to 0 and operands are used unchecked. Results for base >= modulus are undefined.

Verification
REQ-020 SHALL be covered by the following directed scenarios (bench with WORD_W=16, DIGIT_W=5):
- modulus=97, base=50, start pulse -> 32 consecutive writes: addr0=0, addr1=50, addr2=3, addr3=53, addr31=95; done exactly 33 cycles after start.
- modulus=2, base=1 (sum equals modulus) -> entries alternate 0,1,0,1,...; addr31=1.
- modulus=97, base=96 -> addr0=0; addr k = 97-k for k>=1; addr31=66.
- modulus=97, base=0 -> all 32 entries 0; done asserted; err=0.
- rst_n low at write index 10 -> wr_en falls without a clock edge; no writes and no done after release; a fresh start reproduces the full table.
- With XPB_GEN_RANGE_CHECK_EN, modulus=97, base=97 -> err=1 the next cycle, zero writes, no done; a later start with base=50 clears err and writes the full table.
